bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential double-dabble binary-to-BCD converter for the display path. It takes an unsigned binary value with a start pulse and produces packed BCD digits plus per-digit leading-zero enables. Each digit nibble and its enable bit connect straight to one seven-segment decoder (`b[3:0]`, `enable`). Each conversion takes one shift cycle per input bit; results are held until the next conversion completes.

## Interface
- `WIDTH`, 16: binary input width, 4..32.
- `DIGITS`, 5: BCD digits produced. Elaboration fails unless 10^DIGITS > 2^WIDTH − 1.
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a conversion of `bin`; sampled only in IDLE.
- `bin`  in  WIDTH: unsigned value; captured on the accepted `start` edge only.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when `bcd` / `dig_en` update.
- `bcd`  out  4*DIGITS: digit i in `bcd[4i+3:4i]`, digit 0 = least significant; registered.
- `dig_en`  out  DIGITS: bit i = 1 if digit i is to be lit (leading-zero blanking); registered.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - On `start` = 1: load shift register `bin_sr` ← `bin`, scratch `acc` ← 0, counter `cnt` ← WIDTH, go to SHIFT.
  - On `start` = 0: stay in IDLE.
- **SHIFT**, each cycle:
  - For every digit of `acc`: if the nibble ≥ 5, add 3. Adjust all nibbles in parallel, from the current values.
  - Then shift {`acc`, `bin_sr`} left by 1; the MSB of `bin_sr` enters bit 0 of `acc`.
  - Decrement `cnt`. When `cnt` reaches 1 before the decrement (last shift), go to DONE.
- **DONE**
  - Register the final `acc` into `bcd` and compute `dig_en` from it.
  - Return to IDLE next edge.
- `dig_en` rule:
  - `dig_en[0]` = 1 always.
  - `dig_en[i]` = 1 iff digit i, or any higher digit, is nonzero.
- `start` while SHIFT or DONE is ignored; there is no queueing. Changes on `bin` after capture have no effect.
- `acc` never exceeds 9 per nibble after the final shift. Under the DIGITS constraint, no bits are lost off the top.
- Reset, including mid-conversion: state IDLE, `busy` = 0, `done` = 0, `bcd` = 0, `dig_en` = 1 at bit 0 only, `cnt` = 0, `acc` = 0. The aborted conversion produces no `done`.

## Timing
- Accepted `start` at rising edge k:
  - `busy` = 1 from after edge k.
  - Shifts occur at edges k+1 … k+WIDTH.
  - At edge k+WIDTH+1: `bcd` / `dig_en` update, `done` = 1, `busy` = 0.
  - At edge k+WIDTH+2: `done` = 0.
- Latency from `start` to valid result is WIDTH+1 cycles; default 17.
- `busy` = 1 in SHIFT only. `done` = 1 exactly one cycle per completed conversion.
- Throughput: a `start` held high through the `done` cycle is accepted at the edge that ends the `done` cycle (state IDLE). Minimum spacing between accepts is WIDTH+2 cycles.
- `bcd` / `dig_en` are stable between `done` pulses and are glitch-free (registered) for the decoders.

## Test plan
- **Reset:** `rst_n` low mid-stream → `bcd` = 0, `dig_en` = 5'b00001, `busy` = 0, `done` = 0 immediately, independent of `clk`.
- **Zero and max:**
  - `bin` = 0 → `bcd` = 20'h00000, `dig_en` = 5'b00001.
  - `bin` = 65535 → `bcd` = 20'h65535, `dig_en` = 5'b11111.
  - In both cases `done` comes exactly 17 cycles after the `start` edge.
- **Blanking:**
  - `bin` = 1234 → `bcd` = 20'h01234, `dig_en` = 5'b01111.
  - `bin` = 100 → `bcd` = 20'h00100, `dig_en` = 5'b00111.
- **Ignored start:**
  - Start 4321, then pulse `start` with `bin` = 9999 at cycles 3 and 16 → single `done`, `bcd` = 20'h04321.
  - A second `done` appears only after a fresh `start` in IDLE.
- **Abort:**
  - Start 50000, assert `rst_n` = 0 at cycle 8 → no `done`, outputs reset.
  - Restart with 7 → `bcd` = 20'h00007, `dig_en` = 5'b00001.
- **Back-to-back:** hold `start` high with `bin` alternating 9 / 10 per conversion → `done` every 18 cycles, results 00009, 00010. Random sweep of 10k values checked against a reference model.

Source files
------------

// File: rtl/bin2bcd_if.sv
// Start/result handshake between a binary source and the BCD converter.
// The master drives start/bin, and the converter (slave) returns busy/done/bcd/dig_en.
interface bin2bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     dig_en;

  modport master (output start, bin, input busy, done, bcd, dig_en);
  modport slave  (input start, bin, output busy, done, bcd, dig_en);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per input bit, then one cycle
// to register the BCD result and the leading-zero blanking enables.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  bin2bcd_if.slave  io
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  function automatic logic [127:0] pow10(input int n);
    logic [127:0] p;
    p = 128'd1;
    for (int k = 0; k < n; k++) p = p * 128'd10;
    return p;
  endfunction

  if (pow10(DIGITS) <= ((128'd1 << WIDTH) - 128'd1)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    bin_sr_q, bin_sr_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [AW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                done_q, done_d;
  logic [AW-1:0]       adj;
  logic [DIGITS-1:0]   en_calc;
  logic                lit;

  always_comb begin
    adj     = acc_q;
    en_calc = '0;
    lit     = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    // A digit is lit once it or any more significant digit is nonzero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lit        = lit | (|acc_q[4*i +: 4]);
      en_calc[i] = lit;
    end
    en_calc[0] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_sr_d = bin_sr_q;
    acc_d    = acc_q;
    bcd_d    = bcd_q;
    dig_en_d = dig_en_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (io.start) begin
        bin_sr_d = io.bin;
        acc_d    = '0;
        cnt_d    = CW'(WIDTH);
        state_d  = SHIFT;
      end
      SHIFT: begin
        {acc_d, bin_sr_d} = {adj, bin_sr_q} << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d    = acc_q;
        dig_en_d = en_calc;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_sr_q <= '0;
      acc_q    <= '0;
      bcd_q    <= '0;
      dig_en_q <= DIGITS'(1);
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_sr_q <= bin_sr_d;
      acc_q    <= acc_d;
      bcd_q    <= bcd_d;
      dig_en_q <= dig_en_d;
      done_q   <= done_d;
    end
  end

  assign io.busy   = (state_q == SHIFT);
  assign io.done   = done_q;
  assign io.bcd    = bcd_q;
  assign io.dig_en = dig_en_q;
endmodule
